uart_cmd_parser: RTL

//  Parametrised UART command-frame parser for the SDRAM test path; successor to the fixed 8-byte decoder.

---
 rtl/uart_cmd_parser.sv | 120 ++++++++++++
 1 files changed

// File: rtl/uart_cmd_parser.sv
// UART command-frame parser: write frames [WR_OPC][LEN][payload] and read frames [RD_OPC].
// FIFO strobe is combinational; trigger/error pulses are registered one cycle after the cause.
module uart_cmd_parser #(
   parameter int         PAYLOAD_MAX = 8,
   parameter int         LEN_FIELD   = 1,
   parameter logic [7:0] WR_OPC      = 8'h55,
   parameter logic [7:0] RD_OPC      = 8'hAA,
   parameter int         TIMEOUT_CYC = 50000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       uart_data_vld,
   input  logic [7:0] uart_data,
   input  logic       wfifo_full,
   output logic       wfifo_wr_en,
   output logic [7:0] wfifo_data,
   output logic       wr_trig,
   output logic [7:0] wr_len,
   output logic       rd_trig,
   output logic       frame_err,
   output logic       busy
);

   localparam int TW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_LEN     = 2'd1;
   localparam logic [1:0] S_PAYLOAD = 2'd2;
   localparam logic [7:0]    PMAX8 = 8'(PAYLOAD_MAX);
   localparam logic [TW-1:0] TMAX  = TW'(TIMEOUT_CYC);

   logic [1:0]    state;
   logic [7:0]    rem;
   logic [7:0]    len_reg;
   logic          ovf;
   logic [TW-1:0] tcnt;
   logic          timeout;

   assign wfifo_wr_en = uart_data_vld & (state == S_PAYLOAD) & ~wfifo_full;
   assign wfifo_data  = uart_data;
   assign busy        = (state != S_IDLE);

   // A byte arriving in the same cycle the limit is reached takes priority.
   assign timeout = (TIMEOUT_CYC != 0) && (state != S_IDLE) && (tcnt == TMAX) && !uart_data_vld;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tcnt <= '0;
      end else if (uart_data_vld || (state == S_IDLE) || (TIMEOUT_CYC == 0)) begin
         tcnt <= '0;
      end else if (tcnt != TMAX) begin
         tcnt <= tcnt + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         rem       <= 8'd0;
         len_reg   <= 8'd0;
         ovf       <= 1'b0;
         wr_trig   <= 1'b0;
         rd_trig   <= 1'b0;
         frame_err <= 1'b0;
         wr_len    <= 8'd0;
      end else begin
         wr_trig   <= 1'b0;
         rd_trig   <= 1'b0;
         frame_err <= 1'b0;
         if (timeout) begin
            frame_err <= 1'b1;
            state     <= S_IDLE;
            ovf       <= 1'b0;
         end else if (uart_data_vld) begin
            case (state)
               S_IDLE: begin
                  if (uart_data == RD_OPC) begin
                     rd_trig <= 1'b1;
                  end else if (uart_data == WR_OPC) begin
                     if (LEN_FIELD != 0) begin
                        state <= S_LEN;
                     end else begin
                        state   <= S_PAYLOAD;
                        rem     <= PMAX8;
                        len_reg <= PMAX8;
                     end
                  end
               end
               S_LEN: begin
                  if ((uart_data == 8'd0) || (uart_data > PMAX8)) begin
                     frame_err <= 1'b1;
                     state     <= S_IDLE;
                     ovf       <= 1'b0;
                  end else begin
                     rem     <= uart_data;
                     len_reg <= uart_data;
                     state   <= S_PAYLOAD;
                  end
               end
               S_PAYLOAD: begin
                  if (wfifo_full) ovf <= 1'b1;
                  rem <= rem - 1'b1;
                  // Last byte: a drop on this very byte also spoils the frame.
                  if (rem == 8'd1) begin
                     state <= S_IDLE;
                     ovf   <= 1'b0;
                     if (ovf || wfifo_full) begin
                        frame_err <= 1'b1;
                     end else begin
                        wr_trig <= 1'b1;
                        wr_len  <= len_reg;
                     end
                  end
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end

endmodule
